wb_b3_burst_master: RTL and testbench

WB_B3_BURST_MASTER -- requirements
Module: wb_b3_burst_master

---
 rtl/wb_b3_burst_master_if.sv | 32 +++
 rtl/wb_b3_burst_master.sv | 148 ++++++++++++++
 tb/tb_wb_b3_burst_master.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_b3_burst_master_if.sv
// wb_b3_burst_master_if
// Wishbone B3 bus bundle between the burst master and a slave.
//   wb_adr_o/wb_bte_o/wb_cti_o/wb_cyc_o/wb_stb_o/wb_we_o/wb_sel_o/wb_dat_o : master -> slave
//   wb_ack_i/wb_err_i/wb_rty_i/wb_dat_i                                    : slave -> master
// Signal names keep the master-relative _o/_i suffixes used by the rest of the codebase.
interface wb_b3_burst_master_if #(
    parameter int aw = 32,
    parameter int dw = 32
);
    logic [aw-1:0] wb_adr_o;
    logic [1:0]    wb_bte_o;
    logic [2:0]    wb_cti_o;
    logic          wb_cyc_o;
    logic          wb_stb_o;
    logic          wb_we_o;
    logic [3:0]    wb_sel_o;
    logic [dw-1:0] wb_dat_o;
    logic          wb_ack_i;
    logic          wb_err_i;
    logic          wb_rty_i;
    logic [dw-1:0] wb_dat_i;

    modport master (
        output wb_adr_o, wb_bte_o, wb_cti_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_dat_o,
        input  wb_ack_i, wb_err_i, wb_rty_i, wb_dat_i
    );

    modport slave (
        input  wb_adr_o, wb_bte_o, wb_cti_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_dat_o,
        output wb_ack_i, wb_err_i, wb_rty_i, wb_dat_i
    );
endinterface

// File: rtl/wb_b3_burst_master.sv
// wb_b3_burst_master
// Turns a command (start address, direction, 0..16 beats, burst type) into one
// Wishbone B3 registered-feedback burst. Write beats come from a valid/ready
// stream, read beats leave as a one-cycle strobe with registered data.
// Ports:
//   wb_clk_i, wb_rst_i            : clock, synchronous active-high reset
//   cmd_valid_i/cmd_ready_o       : command handshake (ready only when idle)
//   cmd_adr_i/we/len/bte          : command fields, len 0 completes immediately
//   wr_dat_i/wr_valid_i/wr_ready_o: write beat stream
//   rd_dat_o/rd_valid_o           : read beat output, no backpressure
//   done_o, err_o                 : completion pulse, error/abort pulse
//   wb                            : Wishbone master modport
// Optional: define WB_B3_BURST_MASTER_TIMEOUT_EN to abort a burst after 255
// consecutive strobed cycles without any slave termination.
//
// state  | meaning
// IDLE   | no bus cycle, accepting commands
// ACTIVE | cyc high, beats being transferred
module wb_b3_burst_master #(
    parameter int dw = 32,
    parameter int aw = 32
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic [aw-1:0] cmd_adr_i,
    input  logic          cmd_we_i,
    input  logic [4:0]    cmd_len_i,
    input  logic [1:0]    cmd_bte_i,
    input  logic [dw-1:0] wr_dat_i,
    input  logic          wr_valid_i,
    output logic          wr_ready_o,
    output logic [dw-1:0] rd_dat_o,
    output logic          rd_valid_o,
    output logic          done_o,
    output logic          err_o,
    wb_b3_burst_master_if.master wb
);
    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    state_t        state, state_nxt;
    logic [aw-1:0] adr_q, adr_nxt;
    logic [aw-3:0] word_inc;
    logic          we_q;
    logic [1:0]    bte_q;
    logic [4:0]    rem_q;
    logic          single_q;
    logic          cmd_fire;
    logic          stb;
    logic          abort;
    logic          beat_ack;
    logic          last_ack;

    assign cmd_ready_o = (state == IDLE);
    assign cmd_fire    = cmd_valid_i & cmd_ready_o;
    assign stb         = (state == ACTIVE) & (~we_q | wr_valid_i);

`ifdef WB_B3_BURST_MASTER_TIMEOUT_EN
    // Counts consecutive strobed cycles with no termination; the 255th such
    // cycle aborts the burst.
    logic [7:0] tmo_q;
    logic       stall;
    assign stall = stb & ~wb.wb_ack_i & ~wb.wb_err_i & ~wb.wb_rty_i;
    assign abort = (stb & (wb.wb_err_i | wb.wb_rty_i)) | (stall & (tmo_q == 8'd254));

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || !stall) tmo_q <= 8'd0;
        else                    tmo_q <= tmo_q + 8'd1;
    end
`else
    assign abort = stb & (wb.wb_err_i | wb.wb_rty_i);
`endif

    // err/rty win over a simultaneous ack: the beat is dropped.
    assign beat_ack = stb & wb.wb_ack_i & ~abort;
    assign last_ack = beat_ack & (rem_q == 5'd1);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (cmd_fire && cmd_len_i != 5'd0) state_nxt = ACTIVE;
            ACTIVE:  if (abort || last_ack)             state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Wrapping bursts only step the low word-address bits; upper bits stay put.
    assign word_inc = adr_q[aw-1:2] + {{(aw-3){1'b0}}, 1'b1};

    always_comb begin
        adr_nxt = adr_q;
        case (bte_q)
            2'b00:   adr_nxt      = {word_inc, 2'b00};
            2'b01:   adr_nxt[3:2] = adr_q[3:2] + 2'd1;
            2'b10:   adr_nxt[4:2] = adr_q[4:2] + 3'd1;
            default: adr_nxt[5:2] = adr_q[5:2] + 4'd1;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            adr_q      <= '0;
            we_q       <= 1'b0;
            bte_q      <= 2'b00;
            rem_q      <= 5'd0;
            single_q   <= 1'b0;
            rd_dat_o   <= '0;
            rd_valid_o <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            done_o     <= (cmd_fire & (cmd_len_i == 5'd0)) | last_ack | abort;
            err_o      <= abort;
            rd_valid_o <= beat_ack & ~we_q;
            if (beat_ack && !we_q) rd_dat_o <= wb.wb_dat_i;

            if (cmd_fire) begin
                adr_q    <= cmd_adr_i & ~{{(aw-2){1'b0}}, 2'b11};
                we_q     <= cmd_we_i;
                bte_q    <= cmd_bte_i;
                rem_q    <= cmd_len_i;
                single_q <= (cmd_len_i == 5'd1);
            end else if (abort) begin
                rem_q    <= 5'd0;
            end else if (beat_ack) begin
                rem_q    <= rem_q - 5'd1;
                adr_q    <= adr_nxt;
            end
        end
    end

    assign wb.wb_cyc_o = (state == ACTIVE);
    assign wb.wb_stb_o = stb;
    assign wb.wb_we_o  = we_q;
    assign wb.wb_adr_o = adr_q;
    assign wb.wb_bte_o = bte_q;
    assign wb.wb_sel_o = 4'hf;
    assign wb.wb_dat_o = wr_dat_i;
    assign wb.wb_cti_o = (state != ACTIVE || single_q) ? 3'b000 :
                         (rem_q > 5'd1)                ? 3'b010 : 3'b111;
    assign wr_ready_o  = stb & we_q & wb.wb_ack_i;
endmodule

// File: tb/tb_wb_b3_burst_master.sv
module tb_wb_b3_burst_master;
    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [31:0] cmd_adr_i;
    logic        cmd_we_i;
    logic [4:0]  cmd_len_i;
    logic [1:0]  cmd_bte_i;
    logic [31:0] wr_dat_i;
    logic        wr_valid_i;
    logic        wr_ready_o;
    logic [31:0] rd_dat_o;
    logic        rd_valid_o;
    logic        done_o;
    logic        err_o;

    wb_b3_burst_master_if #(.aw(32), .dw(32)) wb ();

    wb_b3_burst_master #(.dw(32), .aw(32)) dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_adr_i   (cmd_adr_i),
        .cmd_we_i    (cmd_we_i),
        .cmd_len_i   (cmd_len_i),
        .cmd_bte_i   (cmd_bte_i),
        .wr_dat_i    (wr_dat_i),
        .wr_valid_i  (wr_valid_i),
        .wr_ready_o  (wr_ready_o),
        .rd_dat_o    (rd_dat_o),
        .rd_valid_o  (rd_valid_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .wb          (wb)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    logic [31:0] mem [0:63];
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Beat i address of a burst, straight from the Wishbone burst rules.
    function automatic logic [31:0] exp_adr(input logic [31:0] start, input logic [1:0] bte, input int i);
        logic [31:0] s;
        logic [31:0] n;
        logic [31:0] base;
        logic [31:0] off;
        s = start & 32'hffff_fffc;
        if (bte == 2'b00) return s + 32'(4 * i);
        n    = 32'(2 << bte);
        base = s & ~(n * 4 - 1);
        off  = ((s - base) / 4 + 32'(i)) % n;
        return base + off * 4;
    endfunction

    function automatic logic [2:0] exp_cti(input int len, input int i);
        if (len == 1)      return 3'b000;
        if (i == len - 1)  return 3'b111;
        return 3'b010;
    endfunction

    // Entered at a falling edge; returns in the done_o cycle so a following
    // call issues its command back-to-back.
    task automatic run_cmd(input logic [31:0] a, input logic we, input int len, input logic [1:0] bte,
                           input int abort_beat, input bit use_rty, input int ack_pct,
                           input int wv_pct, input int gap_beat);
        logic [31:0] wdata [16];
        logic [31:0] cur;
        logic [31:0] rd_exp;
        logic        exp_stb;
        int          beat, cyc_n, stall, gap_left;
        bit          fin, aborted, rd_pend;
        beat = 0; cyc_n = 0; stall = 0; gap_left = 3;
        fin = 0; aborted = 0; rd_pend = 0; rd_exp = '0;
        for (int i = 0; i < 16; i++) wdata[i] = $urandom;

        cmd_valid_i = 1'b1; cmd_adr_i = a; cmd_we_i = we; cmd_len_i = 5'(len); cmd_bte_i = bte;
        wb.wb_ack_i = 1'b0; wb.wb_err_i = 1'b0; wb.wb_rty_i = 1'b0; wr_valid_i = 1'b0;
        #1;
        chk("cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
        @(negedge wb_clk_i);
        cmd_valid_i = 1'b0;
        cmd_adr_i   = $urandom;
        cmd_len_i   = 5'($urandom_range(16));
        if (len == 0) begin
            #1;
            chk("zero_len_done", {31'd0, done_o}, 32'd1);
            chk("zero_len_cyc", {31'd0, wb.wb_cyc_o}, 32'd0);
            chk("zero_len_err", {31'd0, err_o}, 32'd0);
            return;
        end
        while (!fin && cyc_n < 2000) begin
            cyc_n++;
            if (beat == gap_beat && gap_left > 0) begin
                wr_valid_i = 1'b0;
                gap_left--;
            end else begin
                wr_valid_i = ($urandom_range(99) < wv_pct);
            end
            wr_dat_i = wdata[beat];
            if (beat == abort_beat) begin
                wb.wb_ack_i = 1'b0; wb.wb_err_i = !use_rty; wb.wb_rty_i = use_rty;
            end else begin
                wb.wb_ack_i = ($urandom_range(99) < ack_pct); wb.wb_err_i = 1'b0; wb.wb_rty_i = 1'b0;
            end
            #1;
            cur = exp_adr(a, bte, beat);
            wb.wb_dat_i = mem[cur[7:2]];
            exp_stb = !we || wr_valid_i;
            chk("cyc", {31'd0, wb.wb_cyc_o}, 32'd1);
            chk("stb", {31'd0, wb.wb_stb_o}, {31'd0, exp_stb});
            chk("adr", wb.wb_adr_o, cur);
            chk("cti", {29'd0, wb.wb_cti_o}, {29'd0, exp_cti(len, beat)});
            chk("we", {31'd0, wb.wb_we_o}, {31'd0, we});
            chk("bte", {30'd0, wb.wb_bte_o}, {30'd0, bte});
            chk("sel", {28'd0, wb.wb_sel_o}, 32'hf);
            chk("done_mid", {31'd0, done_o}, 32'd0);
            chk("err_mid", {31'd0, err_o}, 32'd0);
            chk("cmd_ready_busy", {31'd0, cmd_ready_o}, 32'd0);
            chk("rd_valid", {31'd0, rd_valid_o}, {31'd0, rd_pend});
            if (rd_pend) chk("rd_dat", rd_dat_o, rd_exp);
            chk("wr_ready", {31'd0, wr_ready_o}, {31'd0, exp_stb && we && wb.wb_ack_i});
            if (exp_stb && we) chk("wb_dat_o", wb.wb_dat_o, wdata[beat]);
            rd_pend = 0;
            if (exp_stb && !wb.wb_ack_i && !wb.wb_err_i && !wb.wb_rty_i) stall++;
            else stall = 0;
            if (exp_stb && (wb.wb_err_i || wb.wb_rty_i)) aborted = 1;
`ifdef WB_B3_BURST_MASTER_TIMEOUT_EN
            if (stall == 255) aborted = 1;
`endif
            if (aborted) begin
                fin = 1;
            end else if (exp_stb && wb.wb_ack_i) begin
                if (we) mem[cur[7:2]] = wdata[beat];
                else begin
                    rd_pend = 1;
                    rd_exp  = mem[cur[7:2]];
                end
                beat++;
                if (beat == len) fin = 1;
            end
            @(negedge wb_clk_i);
        end
        chk("burst_finished", {31'd0, fin}, 32'd1);
        wb.wb_ack_i = 1'b0; wb.wb_err_i = 1'b0; wb.wb_rty_i = 1'b0; wr_valid_i = 1'b0;
        #1;
        chk("end_cyc", {31'd0, wb.wb_cyc_o}, 32'd0);
        chk("end_stb", {31'd0, wb.wb_stb_o}, 32'd0);
        chk("end_done", {31'd0, done_o}, 32'd1);
        chk("end_err", {31'd0, err_o}, {31'd0, aborted});
        chk("end_rd_valid", {31'd0, rd_valid_o}, {31'd0, rd_pend});
        if (rd_pend) chk("end_rd_dat", rd_dat_o, rd_exp);
        chk("end_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
        chk("end_cti", {29'd0, wb.wb_cti_o}, 32'd0);
    endtask

    // Idle cycles with stray slave responses that must be ignored.
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge wb_clk_i);
            cmd_valid_i = 1'b0;
            wb.wb_ack_i = 1'($urandom_range(1));
            wb.wb_err_i = 1'($urandom_range(1));
            wb.wb_rty_i = 1'b0;
            #1;
            chk("idle_cyc", {31'd0, wb.wb_cyc_o}, 32'd0);
            chk("idle_stb", {31'd0, wb.wb_stb_o}, 32'd0);
            chk("idle_done", {31'd0, done_o}, 32'd0);
            chk("idle_err", {31'd0, err_o}, 32'd0);
            chk("idle_rd_valid", {31'd0, rd_valid_o}, 32'd0);
        end
        @(negedge wb_clk_i);
        wb.wb_ack_i = 1'b0; wb.wb_err_i = 1'b0;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        wb_rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_adr_i = '0; cmd_we_i = 1'b0;
        cmd_len_i = '0; cmd_bte_i = '0; wr_dat_i = '0; wr_valid_i = 1'b0;
        wb.wb_ack_i = 1'b0; wb.wb_err_i = 1'b0; wb.wb_rty_i = 1'b0; wb.wb_dat_i = '0;
        repeat (3) @(negedge wb_clk_i);
        #1;
        chk("rst_cyc", {31'd0, wb.wb_cyc_o}, 32'd0);
        chk("rst_stb", {31'd0, wb.wb_stb_o}, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_err", {31'd0, err_o}, 32'd0);
        chk("rst_rd_valid", {31'd0, rd_valid_o}, 32'd0);
        chk("rst_cti", {29'd0, wb.wb_cti_o}, 32'd0);
        chk("rst_adr", wb.wb_adr_o, 32'd0);
        chk("rst_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;

        run_cmd(32'h100, 1'b0, 4, 2'b00, -1, 1'b0, 100, 100, -1);
        idle(2);
        run_cmd(32'h1C, 1'b1, 4, 2'b01, -1, 1'b0, 100, 100, -1);
        idle(1);
        run_cmd(32'h200, 1'b1, 4, 2'b00, -1, 1'b0, 100, 100, 2);
        run_cmd(32'h40, 1'b0, 8, 2'b00, 1, 1'b0, 100, 100, -1);
        run_cmd(32'h80, 1'b0, 0, 2'b00, -1, 1'b0, 100, 100, -1);
        idle(1);
        run_cmd(32'h3F, 1'b0, 1, 2'b10, -1, 1'b0, 60, 100, -1);
        run_cmd(32'h34, 1'b0, 8, 2'b10, -1, 1'b0, 70, 100, -1);
        run_cmd(32'h28, 1'b1, 16, 2'b11, -1, 1'b0, 70, 70, -1);
        run_cmd(32'hC8, 1'b1, 6, 2'b01, 3, 1'b1, 80, 60, -1);

        // Reset in the middle of a read burst.
        idle(1);
        cmd_valid_i = 1'b1; cmd_adr_i = 32'h300; cmd_we_i = 1'b0; cmd_len_i = 5'd8; cmd_bte_i = 2'b00;
        wb.wb_ack_i = 1'b1;
        @(negedge wb_clk_i);
        cmd_valid_i = 1'b0;
        #1;
        chk("mid_rst_pre_cyc", {31'd0, wb.wb_cyc_o}, 32'd1);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        #1;
        chk("mid_rst_cyc", {31'd0, wb.wb_cyc_o}, 32'd0);
        chk("mid_rst_stb", {31'd0, wb.wb_stb_o}, 32'd0);
        chk("mid_rst_done", {31'd0, done_o}, 32'd0);
        chk("mid_rst_err", {31'd0, err_o}, 32'd0);
        chk("mid_rst_rd_valid", {31'd0, rd_valid_o}, 32'd0);
        chk("mid_rst_adr", wb.wb_adr_o, 32'd0);
        wb_rst_i = 1'b0;
        wb.wb_ack_i = 1'b0;
        @(negedge wb_clk_i);
        #1;
        chk("post_rst_done", {31'd0, done_o}, 32'd0);
        chk("post_rst_cyc", {31'd0, wb.wb_cyc_o}, 32'd0);
        @(negedge wb_clk_i);

`ifdef WB_B3_BURST_MASTER_TIMEOUT_EN
        run_cmd(32'h180, 1'b0, 4, 2'b00, -1, 1'b0, 0, 100, -1);
        idle(1);
`endif

        for (int k = 0; k < 40; k++) begin
            len = int'($urandom_range(16));
            run_cmd($urandom, 1'($urandom_range(1)), len, 2'($urandom_range(3)),
                    (len > 0 && $urandom_range(4) == 0) ? int'($urandom_range(len - 1)) : -1,
                    1'($urandom_range(1)), int'($urandom_range(100, 30)),
                    int'($urandom_range(100, 40)), -1);
            if ($urandom_range(1) == 1) idle(int'($urandom_range(2)));
        end
        idle(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
